// File: rtl/ms_delay_timer.sv
// Millisecond countdown timer: counts load_val ms ticks, then emits a one-cycle done pulse.
// Optional feature: define MS_TIMER_PAUSE_EN to add the pause port, which freezes the countdown.
module ms_delay_timer #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ms_tick,
   input  logic             start,
   input  logic [CNT_W-1:0] load_val,
   input  logic             cancel,
`ifdef MS_TIMER_PAUSE_EN
   input  logic             pause,
`endif
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] remaining
);

   // Handshake: start, cancel and ms_tick are single-cycle strobes that need no
   // acknowledge; they are sampled at every rising edge. done is a one-cycle
   // strobe that nobody acknowledges either.

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_EXPIRE = 2'd2
   } state_t;

   state_t state;
   logic   tick_eff;

`ifdef MS_TIMER_PAUSE_EN
   assign tick_eff = ms_tick & ~pause;
`else
   assign tick_eff = ms_tick;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= S_IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         remaining <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            // EXPIRE acts like IDLE for new requests, so done and a reload overlap.
            S_IDLE, S_EXPIRE: begin
               if (start && !cancel) begin
                  if (load_val != '0) begin
                     state     <= S_RUN;
                     busy      <= 1'b1;
                     remaining <= load_val;
                  end else begin
                     state     <= S_EXPIRE;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                     remaining <= '0;
                  end
               end else begin
                  state     <= S_IDLE;
                  busy      <= 1'b0;
                  remaining <= '0;
               end
            end
            S_RUN: begin
               if (cancel) begin
                  state     <= S_IDLE;
                  busy      <= 1'b0;
                  remaining <= '0;
               end else if (start) begin
                  if (load_val != '0) begin
                     remaining <= load_val;
                  end else begin
                     state     <= S_EXPIRE;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                     remaining <= '0;
                  end
               end else if (tick_eff) begin
                  if (remaining <= 1) begin
                     state     <= S_EXPIRE;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                     remaining <= '0;
                  end else begin
                     remaining <= remaining - 1'b1;
                  end
               end
            end
            default: begin
               state     <= S_IDLE;
               busy      <= 1'b0;
               remaining <= '0;
            end
         endcase
      end
   end

endmodule
